run_sequencer: RTL and testbench

Synthesizable run controller that replaces the bench-side bring-up sequence for the TopLevel CPU. On `go` it optionally clears data memory, writes a table of preload words, holds the CPU in start, releases it, waits for `halt` (with a cycle-limit timeout), and then streams a window of result words out over a valid/ready port. It sits beside TopLevel, driving the data-memory write port, the data-memory read address and the CPU `start` pin.

---
 rtl/run_seq_pkg.sv | 28 ++
 rtl/run_sequencer.sv | 174 +++++++++++++++++
 tb/tb_run_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/run_seq_pkg.sv
// Shared types and default constants for the run sequencer.
// Imported by run_sequencer for its state enum and parameter defaults.
package run_seq_pkg;

  localparam int unsigned DefAW        = 8;
  localparam int unsigned DefDW        = 8;
  localparam int unsigned DefDepth     = 256;
  localparam int unsigned DefNload     = 16;
  localparam int unsigned DefNres      = 8;
  localparam int unsigned DefCw        = 16;
  localparam int unsigned DefMaxCycles = 32'h0000_FFFF;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StLoad,
    StLaunch,
    StRun,
    StDump,
    StDone,
    StTimeout
  } run_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/run_sequencer.sv
// Bring-up controller for the CPU: clears/preloads data memory, launches the CPU,
// waits for halt (with cycle limit) and streams a window of result words out.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int unsigned AW         = DefAW,
  parameter int unsigned DW         = DefDW,
  parameter int unsigned DEPTH      = DefDepth,
  parameter int unsigned NLOAD      = DefNload,
  parameter int unsigned NRES       = DefNres,
  parameter int unsigned CW         = DefCw,
  parameter int unsigned MAX_CYCLES = DefMaxCycles
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       go,
  input  logic                       clear_en,
  input  logic [$clog2(NLOAD+1)-1:0] tbl_count,
  output logic [$clog2(NLOAD)-1:0]   tbl_idx,
  input  logic [AW-1:0]              tbl_addr,
  input  logic [DW-1:0]              tbl_data,
  input  logic [AW-1:0]              res_base,
  output logic                       mem_we,
  output logic [AW-1:0]              mem_waddr,
  output logic [DW-1:0]              mem_wdata,
  output logic [AW-1:0]              mem_raddr,
  input  logic [DW-1:0]              mem_rdata,
  output logic                       cpu_start,
  input  logic                       cpu_halt,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [$clog2(NRES)-1:0]    res_idx,
  output logic [DW-1:0]              res_data,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout,
  output logic [CW-1:0]              cycles
);

  localparam int unsigned TIW  = $clog2(NLOAD);
  localparam int unsigned TCW  = $clog2(NLOAD + 1);
  localparam int unsigned RIW  = $clog2(NRES);
  localparam int unsigned CntW = max_u(AW, max_u(TCW, RIW));

  run_state_t         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [AW-1:0]      base_q, base_d;
  logic [CW-1:0]      cycles_q, cycles_d, run_cnt;

  assign cnt_inc = cnt_q + CntW'(1);
  assign run_cnt = cycles_q + CW'(1);

  // One counter serves as clear address, table index and result index.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    cycles_d = cycles_q;
    unique case (state_q)
      StIdle, StDone, StTimeout: begin
        if (go) begin
          base_d   = res_base;
          cycles_d = '0;
          cnt_d    = '0;
          if (clear_en) begin
            state_d = StClear;
          end else if (tbl_count == '0) begin
            state_d = StLaunch;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StClear: begin
        cnt_d = cnt_inc;
        if (cnt_q == CntW'(DEPTH - 1)) begin
          cnt_d   = '0;
          state_d = (tbl_count == '0) ? StLaunch : StLoad;
        end
      end
      StLoad: begin
        cnt_d = cnt_inc;
        if (CntW'(tbl_count) == cnt_inc) begin
          cnt_d   = '0;
          state_d = StLaunch;
        end
      end
      StLaunch: state_d = StRun;
      StRun: begin
        // The halting cycle is counted; halt wins over the cycle limit.
        cycles_d = run_cnt;
        if (cpu_halt) begin
          cnt_d   = '0;
          state_d = StDump;
        end else if (run_cnt == CW'(MAX_CYCLES)) begin
          state_d = StTimeout;
        end
      end
      StDump: begin
        if (res_ready) begin
          if (cnt_q == CntW'(NRES - 1)) begin
            cnt_d   = '0;
            state_d = StDone;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      base_q   <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      cycles_q <= cycles_d;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_raddr = '0;
    tbl_idx   = '0;
    res_valid = 1'b0;
    res_idx   = '0;
    res_data  = '0;
    cpu_start = 1'b1;
    busy      = 1'b1;
    done      = 1'b0;
    timeout   = 1'b0;
    unique case (state_q)
      StIdle:   busy = 1'b0;
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q[AW-1:0];
      end
      StLoad: begin
        mem_we    = 1'b1;
        tbl_idx   = cnt_q[TIW-1:0];
        mem_waddr = tbl_addr;
        mem_wdata = tbl_data;
      end
      StLaunch: cpu_start = 1'b1;
      StRun:    cpu_start = 1'b0;
      StDump: begin
        res_valid = 1'b1;
        res_idx   = cnt_q[RIW-1:0];
        mem_raddr = base_q + AW'(cnt_q[RIW-1:0]);
        res_data  = mem_rdata;
      end
      StDone: begin
        busy = 1'b0;
        done = 1'b1;
      end
      StTimeout: begin
        busy    = 1'b0;
        timeout = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  assign cycles = cycles_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Randomized bench for run_sequencer: memory and CPU environment models plus a
// per-run reference of expected writes, launch latency, cycle count and dump.
module tb_run_sequencer;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned NLOAD = 16;
  localparam int unsigned NRES  = 4;
  localparam int unsigned CW    = 16;
  localparam int unsigned MAXC  = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, go, clear_en, res_ready, cpu_halt;
  logic          mem_we, cpu_start, res_valid, busy, done, timeout;
  logic [4:0]    tbl_count;
  logic [3:0]    tbl_idx;
  logic [AW-1:0] tbl_addr, res_base, mem_waddr, mem_raddr;
  logic [DW-1:0] tbl_data, mem_wdata, mem_rdata, res_data;
  logic [1:0]    res_idx;
  logic [CW-1:0] cycles;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [AW-1:0] tbl_a   [NLOAD];
  logic [DW-1:0] tbl_d   [NLOAD];
  int            run_ctr = 0;
  int            halt_at = 0;
  logic          halt_noise;

  int n_checks = 0;
  int n_errors = 0;

  run_sequencer #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .NLOAD(NLOAD), .NRES(NRES), .CW(CW), .MAX_CYCLES(MAXC)
  ) dut (
    .CLK(clk), .reset(reset), .go(go), .clear_en(clear_en), .tbl_count(tbl_count),
    .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_data(tbl_data), .res_base(res_base),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .cpu_start(cpu_start), .cpu_halt(cpu_halt), .res_valid(res_valid),
    .res_ready(res_ready), .res_idx(res_idx), .res_data(res_data), .busy(busy), .done(done),
    .timeout(timeout), .cycles(cycles)
  );

  // Environment: data memory, table lookup, and a CPU that halts on its Nth running cycle.
  assign tbl_addr  = tbl_a[tbl_idx];
  assign tbl_data  = tbl_d[tbl_idx];
  assign mem_rdata = mem[mem_raddr];
  assign cpu_halt  = cpu_start ? halt_noise : (run_ctr + 1 == halt_at);

  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    run_ctr <= cpu_start ? 0 : run_ctr + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_start"}, cpu_start, 1);
    check_eq({tag, "_we"}, mem_we, 0);
    check_eq({tag, "_waddr"}, mem_waddr, 0);
    check_eq({tag, "_raddr"}, mem_raddr, 0);
    check_eq({tag, "_tidx"}, tbl_idx, 0);
    check_eq({tag, "_valid"}, res_valid, 0);
    check_eq({tag, "_ridx"}, res_idx, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_timeout"}, timeout, 0);
    check_eq({tag, "_cycles"}, cycles, 0);
  endtask

  task automatic fill_tbl(input logic [AW-1:0] base, input int win);
    for (int i = 0; i < NLOAD; i++) begin
      tbl_a[i] = AW'(base + $urandom_range(0, win));
      tbl_d[i] = DW'($urandom_range(1, 255));
    end
  endtask

  // rmode: 0 = always ready, 1 = ready pattern 1,0,0,1, 2 = random ready.
  task automatic do_run(input bit clr, input int n, input logic [AW-1:0] base, input int hat,
                        input int rmode, input bit go_in_run);
    logic [AW-1:0] ea[$];
    logic [DW-1:0] ed[$];
    int nw, exp_fall, exp_cyc, cyc, widx, fall, dcount, rk, bad;
    bit exp_to, r, go_sent;
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        ea.push_back(AW'(i));
        ed.push_back('0);
        ref_mem[i] = '0;
      end
    end
    for (int i = 0; i < n; i++) begin
      ea.push_back(tbl_a[i]);
      ed.push_back(tbl_d[i]);
      ref_mem[tbl_a[i]] = tbl_d[i];
    end
    nw       = ea.size();
    exp_fall = nw + 2;
    exp_to   = (hat == 0) || (hat > int'(MAXC));
    exp_cyc  = exp_to ? MAXC : hat;
    halt_at  = hat;

    @(negedge clk);
    go = 1'b1; clear_en = clr; tbl_count = 5'(n); res_base = base;
    @(negedge clk);
    go = 1'b0; clear_en = 1'($urandom); res_base = AW'($urandom);
    cyc = 1; widx = 0; fall = -1; dcount = 0; rk = 0; go_sent = 1'b0;
    while (cyc < 1000 && !(done || timeout)) begin
      if (mem_we) begin
        if (widx < nw) begin
          check_eq("wcyc", cyc, widx + 1);
          check_eq("waddr", mem_waddr, ea[widx]);
          check_eq("wdata", mem_wdata, ed[widx]);
        end else begin
          check_eq("wcount", widx + 1, nw);
        end
        widx++;
      end
      check_eq("busy", busy, 1);
      if (fall < 0 && !cpu_start) begin
        fall = cyc;
        check_eq("fall", fall, exp_fall);
      end
      go = 1'b0;
      if (go_in_run && fall > 0 && !go_sent && !cpu_start) begin
        go = 1'b1; clear_en = 1'b1; go_sent = 1'b1;
      end
      if (res_valid) begin
        check_eq("dump_on_timeout", exp_to, 0);
        check_eq("ridx", res_idx, dcount);
        check_eq("raddr", mem_raddr, AW'(base + dcount));
        check_eq("rdata", res_data, ref_mem[AW'(base + dcount)]);
        case (rmode)
          0:       r = 1'b1;
          1:       r = (rk % 4 == 0) || (rk % 4 == 3);
          default: r = 1'($urandom);
        endcase
        rk++;
        if (r) dcount++;
      end else begin
        r = 1'($urandom);
      end
      res_ready  = r;
      halt_noise = 1'($urandom);
      @(negedge clk);
      cyc++;
    end
    go = 1'b0;
    check_eq("end", done | timeout, 1);
    check_eq("done", done, !exp_to);
    check_eq("timeout", timeout, exp_to);
    check_eq("cycles", cycles, exp_cyc);
    check_eq("nwrites", widx, nw);
    check_eq("ndump", dcount, exp_to ? 0 : NRES);
    check_eq("cpu_hold", cpu_start, 1);
    if (fall < 0) check_eq("fall", fall, exp_fall);
    repeat (2) begin
      @(negedge clk);
      halt_noise = 1'($urandom);
      res_ready  = 1'($urandom);
    end
    check_eq("hold_cycles", cycles, exp_cyc);
    check_eq("hold_done", done, !exp_to);
    check_eq("hold_valid", res_valid, 0);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
    check_eq("mem", bad, 0);
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; clear_en = 1'b0; tbl_count = '0; res_base = '0;
    res_ready = 1'b0; halt_noise = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_idle("reset");

    // Clear plus two-entry table; launch 260 cycles after go.
    fill_tbl(8'h00, 7);
    tbl_a[0] = 8'h01; tbl_d[0] = 8'h24;
    tbl_a[1] = 8'h02; tbl_d[1] = 8'h01;
    do_run(1'b1, 2, 8'h00, 10, 0, 1'b0);

    // Empty table, no clear: LAUNCH straight after go.
    do_run(1'b0, 0, 8'h00, 10, 0, 1'b0);

    // Wrapping dump window with stalls; repeated table addresses.
    fill_tbl(8'hFE, 3);
    do_run(1'b0, 10, 8'hFE, 5, 1, 1'b0);

    // No halt: timeout after MAXC run cycles.
    fill_tbl(8'h10, 4);
    do_run(1'b0, 3, 8'h10, 0, 0, 1'b0);

    // Reset in the middle of CLEAR.
    @(negedge clk);
    go = 1'b1; clear_en = 1'b1; tbl_count = '0; res_base = '0;
    @(negedge clk);
    go = 1'b0;
    for (int k = 0; k < 300 && !(mem_we && mem_waddr == 8'h40); k++) @(negedge clk);
    check_eq("rst_at_40", mem_waddr, 8'h40);
    reset = 1'b1;
    for (int i = 0; i <= 8'h40; i++) ref_mem[i] = '0;
    @(negedge clk);
    reset = 1'b0;
    check_idle("mid_rst");

    // Fresh clear; halt coincides with the cycle limit; go pulsed during RUN.
    fill_tbl(8'h00, 5);
    do_run(1'b1, 4, 8'h00, MAXC, 2, 1'b1);

    for (int t = 0; t < 5; t++) begin
      bit            c;
      int            n, h, rm;
      logic [AW-1:0] b;
      c  = ($urandom_range(0, 3) == 0);
      n  = $urandom_range(0, NLOAD);
      b  = AW'($urandom);
      h  = $urandom_range(0, 25);
      rm = $urandom_range(0, 2);
      fill_tbl(b, 6);
      do_run(c, n, b, h, rm, (h >= 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
